// File: rtl/data_sync_hs_if.sv
// data_sync_hs_if
//   Groups the handshake and data signals of the data_sync_hs bus synchronizer.
//   master : the side that drives the incoming word, enable toggle, out_ready
//            and ovr_clr, and observes the buffered outputs.
//   slave  : the synchronizer itself.
//   Signals:
//     unsync_bus   source-domain word (held stable across the transfer)
//     bus_enable   source-domain toggle, one level change per word
//     out_ready    downstream accepts out_data while out_valid=1
//     ovr_clr      clears the sticky overrun flag
//     out_data     buffered synchronized word
//     out_valid    out_data holds an unconsumed word
//     enable_pulse one-cycle pulse when out_data is loaded
//     drop_pulse   one-cycle pulse when an incoming word is discarded
//     overrun      sticky drop indicator
//     word_cnt     wrapping count of loaded words
interface data_sync_hs_if #(
    parameter int BUS_WIDTH = 8,
    parameter int CNT_WIDTH = 8
);
    logic [BUS_WIDTH-1:0] unsync_bus;
    logic                 bus_enable;
    logic                 out_ready;
    logic                 ovr_clr;
    logic [BUS_WIDTH-1:0] out_data;
    logic                 out_valid;
    logic                 enable_pulse;
    logic                 drop_pulse;
    logic                 overrun;
    logic [CNT_WIDTH-1:0] word_cnt;

    modport master (
        output unsync_bus, bus_enable, out_ready, ovr_clr,
        input  out_data, out_valid, enable_pulse, drop_pulse, overrun, word_cnt
    );

    modport slave (
        input  unsync_bus, bus_enable, out_ready, ovr_clr,
        output out_data, out_valid, enable_pulse, drop_pulse, overrun, word_cnt
    );
endinterface

// File: rtl/data_sync_hs.sv
// data_sync_hs
//   Destination-domain synchronizer for a multi-bit word qualified by a
//   toggling enable. The enable runs through a NUM_STAGES flop chain, is
//   edge-detected, and each detected toggle captures unsync_bus into a
//   one-entry valid/ready buffer. Words arriving while the buffer is full
//   and not being drained are dropped and flagged.
//   Ports:
//     clk  destination clock
//     RST  synchronous active-high reset (from the domain reset synchronizer)
//     bus  data_sync_hs_if.slave -- word, toggle, handshake, status outputs
module data_sync_hs #(
    parameter int NUM_STAGES = 2,
    parameter int BUS_WIDTH  = 8,
    parameter int CNT_WIDTH  = 8
) (
    input  logic          clk,
    input  logic          RST,
    data_sync_hs_if.slave bus
);
    localparam int BLANK_W = $clog2(NUM_STAGES + 2);
    localparam logic [BLANK_W-1:0] BLANK_INIT = BLANK_W'(NUM_STAGES + 1);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t                r_state;
    logic [NUM_STAGES-1:0] r_sync;
    logic                  r_en_prev;
    logic [BLANK_W-1:0]    r_blank;
    logic [BUS_WIDTH-1:0]  r_out_data;
    logic                  r_enable_pulse;
    logic                  r_drop_pulse;
    logic                  r_overrun;
    logic [CNT_WIDTH-1:0]  r_word_cnt;

    logic w_last;
    logic w_tog;
    logic w_pop;
    logic w_load;
    logic w_drop;

    assign w_last = r_sync[NUM_STAGES-1];
    // Blanking masks detection until the chain has flushed whatever level
    // bus_enable held at reset release, so a stuck-high enable is not a word.
    assign w_tog  = (r_blank == '0) && (w_last ^ r_en_prev);
    assign w_pop  = (r_state == FULL) && bus.out_ready;
    // Load when empty, or when the held word is drained in the same cycle.
    assign w_load = w_tog && ((r_state == EMPTY) || w_pop);
    assign w_drop = w_tog && (r_state == FULL) && !bus.out_ready;

    always_ff @(posedge clk) begin
        if (RST) begin
            r_state        <= EMPTY;
            r_sync         <= '0;
            r_en_prev      <= 1'b0;
            r_blank        <= BLANK_INIT;
            r_out_data     <= '0;
            r_enable_pulse <= 1'b0;
            r_drop_pulse   <= 1'b0;
            r_overrun      <= 1'b0;
            r_word_cnt     <= '0;
        end else begin
            r_sync    <= {r_sync[NUM_STAGES-2:0], bus.bus_enable};
            r_en_prev <= w_last;
            if (r_blank != '0) begin
                r_blank <= r_blank - 1'b1;
            end

            r_enable_pulse <= w_load;
            r_drop_pulse   <= w_drop;

            case (r_state)
                EMPTY: begin
                    if (w_load) begin
                        r_state <= FULL;
                    end
                end
                FULL: begin
                    if (w_pop && !w_tog) begin
                        r_state <= EMPTY;
                    end
                end
                default: r_state <= EMPTY;
            endcase

            if (w_load) begin
                r_out_data <= bus.unsync_bus;
                r_word_cnt <= r_word_cnt + CNT_WIDTH'(1);
            end

            // A drop in the same cycle as a clear keeps the flag set.
            if (w_drop) begin
                r_overrun <= 1'b1;
            end else if (bus.ovr_clr) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign bus.out_data     = r_out_data;
    assign bus.out_valid    = (r_state == FULL);
    assign bus.enable_pulse = r_enable_pulse;
    assign bus.drop_pulse   = r_drop_pulse;
    assign bus.overrun      = r_overrun;
    assign bus.word_cnt     = r_word_cnt;
endmodule

// File: tb/tb_data_sync_hs.sv
module tb_data_sync_hs;
    logic clk;
    logic RST;
    int   n_checks;
    int   n_pass;

    data_sync_hs_if #(.BUS_WIDTH(8), .CNT_WIDTH(8)) bus ();

    data_sync_hs #(.NUM_STAGES(2), .BUS_WIDTH(8), .CNT_WIDTH(8)) dut (
        .clk (clk),
        .RST (RST),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge; inputs change and outputs are sampled 1ns later.
    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic toggle(input logic [7:0] d);
        bus.unsync_bus = d;
        bus.bus_enable = ~bus.bus_enable;
    endtask

    // Reset with the current bus_enable level held, then wait out blanking.
    task automatic apply_reset();
        bus.ovr_clr = 1'b0;
        RST = 1'b1;
        tick(2);
        RST = 1'b0;
        tick(5);
    endtask

    task automatic test_reset();
        int seen;
        bus.unsync_bus = 8'h00;
        bus.bus_enable = 1'b1;
        bus.out_ready  = 1'b0;
        bus.ovr_clr    = 1'b0;
        RST = 1'b1;
        tick(2);
        n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL rst_valid: got %0b want 0", bus.out_valid); else n_pass++;
        n_checks++; if (bus.out_data !== 8'h00) $display("FAIL rst_data: got %h want 00", bus.out_data); else n_pass++;
        n_checks++; if ({bus.enable_pulse, bus.drop_pulse, bus.overrun} !== 3'b000) $display("FAIL rst_flags: got %b want 000", {bus.enable_pulse, bus.drop_pulse, bus.overrun}); else n_pass++;
        n_checks++; if (bus.word_cnt !== 8'd0) $display("FAIL rst_cnt: got %0d want 0", bus.word_cnt); else n_pass++;
        RST = 1'b0;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.enable_pulse === 1'b1) seen++;
        end
        n_checks++; if (seen !== 0) $display("FAIL blank_pulse: got %0d pulses want 0", seen); else n_pass++;
        n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL blank_valid: got %0b want 0", bus.out_valid); else n_pass++;
        n_checks++; if (bus.word_cnt !== 8'd0) $display("FAIL blank_cnt: got %0d want 0", bus.word_cnt); else n_pass++;
    endtask

    task automatic test_single();
        bus.bus_enable = 1'b0;
        bus.out_ready  = 1'b1;
        apply_reset();
        toggle(8'hA5);
        tick(2);
        n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL single_early: got valid %0b want 0 at edge 2", bus.out_valid); else n_pass++;
        tick();
        n_checks++; if (bus.out_data !== 8'hA5) $display("FAIL single_data: got %h want a5", bus.out_data); else n_pass++;
        n_checks++; if ({bus.out_valid, bus.enable_pulse} !== 2'b11) $display("FAIL single_vp: got %b want 11", {bus.out_valid, bus.enable_pulse}); else n_pass++;
        n_checks++; if (bus.word_cnt !== 8'd1) $display("FAIL single_cnt: got %0d want 1", bus.word_cnt); else n_pass++;
        tick();
        n_checks++; if ({bus.out_valid, bus.enable_pulse} !== 2'b00) $display("FAIL single_pop: got %b want 00", {bus.out_valid, bus.enable_pulse}); else n_pass++;
    endtask

    task automatic test_overrun();
        bus.out_ready = 1'b0;
        apply_reset();
        toggle(8'h11);
        tick(6);
        n_checks++; if ({bus.out_valid, bus.out_data} !== {1'b1, 8'h11}) $display("FAIL ovr_first: got %b/%h want 1/11", bus.out_valid, bus.out_data); else n_pass++;
        toggle(8'h22);
        tick(2);
        n_checks++; if (bus.drop_pulse !== 1'b0) $display("FAIL ovr_early: got drop %0b want 0", bus.drop_pulse); else n_pass++;
        tick();
        n_checks++; if ({bus.drop_pulse, bus.overrun, bus.enable_pulse} !== 3'b110) $display("FAIL ovr_drop: got %b want 110", {bus.drop_pulse, bus.overrun, bus.enable_pulse}); else n_pass++;
        n_checks++; if (bus.out_data !== 8'h11) $display("FAIL ovr_hold: got %h want 11", bus.out_data); else n_pass++;
        n_checks++; if (bus.word_cnt !== 8'd1) $display("FAIL ovr_cnt: got %0d want 1", bus.word_cnt); else n_pass++;
        tick();
        n_checks++; if ({bus.drop_pulse, bus.overrun, bus.out_valid} !== 3'b011) $display("FAIL ovr_after: got %b want 011", {bus.drop_pulse, bus.overrun, bus.out_valid}); else n_pass++;
        bus.out_ready = 1'b1;
        tick();
        n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL ovr_pop: got valid %0b want 0", bus.out_valid); else n_pass++;
    endtask

    task automatic test_back_to_back();
        bus.out_ready = 1'b0;
        apply_reset();
        toggle(8'h44);
        tick(6);
        n_checks++; if ({bus.out_valid, bus.out_data} !== {1'b1, 8'h44}) $display("FAIL b2b_first: got %b/%h want 1/44", bus.out_valid, bus.out_data); else n_pass++;
        toggle(8'h33);
        tick(2);
        bus.out_ready = 1'b1;
        tick();
        n_checks++; if ({bus.out_valid, bus.out_data} !== {1'b1, 8'h33}) $display("FAIL b2b_data: got %b/%h want 1/33", bus.out_valid, bus.out_data); else n_pass++;
        n_checks++; if ({bus.enable_pulse, bus.drop_pulse, bus.overrun} !== 3'b100) $display("FAIL b2b_flags: got %b want 100", {bus.enable_pulse, bus.drop_pulse, bus.overrun}); else n_pass++;
        n_checks++; if (bus.word_cnt !== 8'd2) $display("FAIL b2b_cnt: got %0d want 2", bus.word_cnt); else n_pass++;
        tick();
        n_checks++; if ({bus.out_valid, bus.enable_pulse} !== 2'b00) $display("FAIL b2b_pop: got %b want 00", {bus.out_valid, bus.enable_pulse}); else n_pass++;
    endtask

    task automatic test_ovr_clr();
        bus.out_ready = 1'b0;
        apply_reset();
        toggle(8'h55);
        tick(6);
        toggle(8'h66);
        tick(2);
        bus.ovr_clr = 1'b1;
        tick();
        n_checks++; if ({bus.drop_pulse, bus.overrun} !== 2'b11) $display("FAIL clr_setwins: got %b want 11", {bus.drop_pulse, bus.overrun}); else n_pass++;
        tick();
        n_checks++; if (bus.overrun !== 1'b0) $display("FAIL clr_alone: got %0b want 0", bus.overrun); else n_pass++;
        bus.ovr_clr = 1'b0;
        tick();
        n_checks++; if ({bus.overrun, bus.out_data} !== {1'b0, 8'h55}) $display("FAIL clr_after: got %b/%h want 0/55", bus.overrun, bus.out_data); else n_pass++;
    endtask

    task automatic test_wrap();
        int pulses;
        bus.out_ready = 1'b1;
        apply_reset();
        pulses = 0;
        for (int i = 0; i < 256; i++) begin
            toggle(8'(i));
            for (int k = 0; k < 6; k++) begin
                tick();
                if (bus.enable_pulse === 1'b1) pulses++;
            end
            if (i == 254) begin
                n_checks++; if (bus.word_cnt !== 8'd255) $display("FAIL wrap_255: got %0d want 255", bus.word_cnt); else n_pass++;
            end
        end
        n_checks++; if (pulses !== 256) $display("FAIL wrap_pulses: got %0d want 256", pulses); else n_pass++;
        n_checks++; if (bus.word_cnt !== 8'd0) $display("FAIL wrap_cnt: got %0d want 0", bus.word_cnt); else n_pass++;
        n_checks++; if ({bus.out_data, bus.overrun} !== {8'hFF, 1'b0}) $display("FAIL wrap_last: got %h/%b want ff/0", bus.out_data, bus.overrun); else n_pass++;
    endtask

    task automatic test_reset_mid();
        bus.out_ready = 1'b0;
        apply_reset();
        toggle(8'h77);
        tick(3);
        n_checks++; if ({bus.out_valid, bus.out_data} !== {1'b1, 8'h77}) $display("FAIL mid_full: got %b/%h want 1/77", bus.out_valid, bus.out_data); else n_pass++;
        toggle(8'h88);
        tick();
        RST = 1'b1;
        tick();
        n_checks++; if ({bus.out_valid, bus.out_data, bus.enable_pulse, bus.drop_pulse, bus.overrun, bus.word_cnt} !== 20'd0)
            $display("FAIL mid_rst: got %b/%h/%b%b%b/%0d want all 0", bus.out_valid, bus.out_data, bus.enable_pulse, bus.drop_pulse, bus.overrun, bus.word_cnt);
        else n_pass++;
        RST = 1'b0;
        tick(10);
        n_checks++; if ({bus.out_valid, bus.word_cnt} !== 9'd0) $display("FAIL mid_after: got %b/%0d want 0/0", bus.out_valid, bus.word_cnt); else n_pass++;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        RST      = 1'b1;
        test_reset();
        test_single();
        test_overrun();
        test_back_to_back();
        test_ovr_clr();
        test_wrap();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
